// File: rtl/booth_divider.sv
// Sequential restoring divider, one quotient bit per cycle.
// Remainder on ansHI, quotient on ansLO, start/busy/done handshake.
module booth_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] ansHI,
  output logic [WIDTH-1:0] ansLO,
  output logic             busy,
  output logic             done,
  output logic             divByZero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FIXUP,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             negq;
  logic             negr;
  logic             dz;

  logic load, step, fix, fin;

  logic             dvd_neg;
  logic             dvs_neg;
  logic             dvs_zero;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   t;

  assign dvd_neg  = isSigned & dividend[WIDTH-1];
  assign dvs_neg  = isSigned & divisor[WIDTH-1];
  assign dvs_zero = (divisor == '0);
  assign dvd_mag  = dvd_neg ? -dividend : dividend;
  assign dvs_mag  = dvs_neg ? -divisor : divisor;

  // r < dvs always, so the sign bit of t decides the trial subtract
  assign t = {r, q[WIDTH-1]} - {1'b0, dvs};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = dvs_zero ? FIN : DIVIDE;
      end
      DIVIDE: begin
        if (cnt == '0) state_nx = FIXUP;
      end
      FIXUP:   state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    step = 1'b0;
    fix  = 1'b0;
    fin  = 1'b0;
    unique case (state)
      IDLE:   load = start;
      DIVIDE: begin
        busy = 1'b1;
        step = 1'b1;
      end
      FIXUP: begin
        busy = 1'b1;
        fix  = 1'b1;
      end
      FIN:     fin = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r         <= '0;
      q         <= '0;
      dvs       <= '0;
      cnt       <= '0;
      negq      <= 1'b0;
      negr      <= 1'b0;
      dz        <= 1'b0;
      ansHI     <= '0;
      ansLO     <= '0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        negq      <= dvd_neg ^ dvs_neg;
        negr      <= dvd_neg;
        dz        <= dvs_zero;
        r         <= '0;
        q         <= dvs_zero ? dividend : dvd_mag;
        dvs       <= dvs_mag;
        cnt       <= CW'(WIDTH - 1);
        divByZero <= 1'b0;
      end
      if (step) begin
        if (!t[WIDTH]) begin
          r <= t[WIDTH-1:0];
          q <= {q[WIDTH-2:0], 1'b1};
        end else begin
          r <= {r[WIDTH-2:0], q[WIDTH-1]};
          q <= {q[WIDTH-2:0], 1'b0};
        end
        if (cnt != '0) cnt <= cnt - CW'(1);
      end
      if (fix) begin
        ansLO <= negq ? -q : q;
        ansHI <= negr ? -r : r;
      end
      // q still holds the raw dividend on the zero-divisor path
      if (fin && dz) begin
        ansLO     <= '1;
        ansHI     <= q;
        divByZero <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Directed and random checks of booth_divider
// against an arithmetic reference model.
module tb_booth_divider;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        isSigned;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] ansHI;
  logic [31:0] ansLO;
  logic        busy;
  logic        done;
  logic        divByZero;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  booth_divider #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .isSigned(isSigned),
    .dividend(dividend),
    .divisor(divisor),
    .ansHI(ansHI),
    .ansLO(ansLO),
    .busy(busy),
    .done(done),
    .divByZero(divByZero)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input bit s,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] eq,
                                output logic [31:0] er);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else if (!s) begin
      eq = a / b;
      er = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      eq = 32'h8000_0000;
      er = 32'd0;
    end else begin
      eq = sa / sb;
      er = sa % sb;
    end
  endfunction

  task automatic run_op(input bit s,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int inject);
    logic [31:0] eq;
    logic [31:0] er;
    int n;
    int nb;
    bit seen;
    model(s, a, b, eq, er);
    isSigned = s;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    chk("done_low_at_start", done, 0);
    chk("dbz_clear_at_start", divByZero, 0);
    nb   = int'(busy);
    n    = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      if (n == inject) begin
        start    = 1'b1;
        isSigned = ~s;
        dividend = 32'h0BAD_F00D;
        divisor  = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      n++;
      if (done) seen = 1'b1;
      else nb += int'(busy);
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    chk("latency", n, (b == 0) ? 1 : 34);
    chk("busy_cycles", nb, (b == 0) ? 0 : 33);
    chk("quotient", ansLO, eq);
    chk("remainder", ansHI, er);
    chk("div_by_zero", divByZero, b == 0);
    chk("busy_at_done", busy, 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    bit s;
    int dones;

    reset    = 1'b1;
    start    = 1'b0;
    isSigned = 1'b0;
    dividend = 32'd0;
    divisor  = 32'd0;
    #1;
    chk("rst_ansHI", ansHI, 0);
    chk("rst_ansLO", ansLO, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", divByZero, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    run_op(0, 32'd100, 32'd7, -1);
    run_op(1, 32'hFFFF_FF9C, 32'd7, -1);
    run_op(1, 32'd100, 32'hFFFF_FFF9, -1);
    run_op(0, 32'hFFFF_FFFF, 32'd2, -1);
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(0, 32'h1234_5678, 32'd0, -1);
    run_op(0, 32'd50, 32'd5, -1);
    run_op(1, 32'hFFFF_FC18, 32'd7, 4);
    run_op(0, 32'd1000, 32'd13, 33);
    run_op(1, 32'h8000_0000, 32'd0, -1);

    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2, 3: b = $urandom_range(1, 20);
        4:       b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if (b == 32'd0 && $urandom_range(0, 1) == 1) b = 32'd1;
      run_op(s, a, b, (i % 4 == 0) ? 5 : -1);
    end

    run_op(0, 32'd77, 32'd5, -1);

    isSigned = 1'b0;
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    chk("busy_mid_op", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_ansHI", ansHI, 0);
    chk("abort_ansLO", ansLO, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dbz", divByZero, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      dones += int'(done);
    end
    chk("no_done_after_abort", dones, 0);
    run_op(0, 32'd9, 32'd3, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential 32-bit integer divider; the inverse companion of the combinational Booth multiplier.
- Computes quotient and remainder with one restoring-division step per cycle, signed or unsigned.
- Results appear on the same HI/LO pair the multiplier drives: ansHI = remainder, ansLO = quotient. They feed the HI/LO registers of the datapath.
- Control unit uses a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand and result width. Iteration count equals WIDTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- isSigned  in  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start
- dividend  in  WIDTH  numerator; captured with start
- divisor  in  WIDTH  denominator; captured with start
- ansHI  out  WIDTH  remainder
- ansLO  out  WIDTH  quotient
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse; results valid
- divByZero  out  1  set with done when the divisor was zero

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - ansHI, ansLO, busy, done and divByZero are all 0.
  - Internal registers are cleared.
  - Asserting reset mid-operation aborts the operation with no done pulse.
- States: IDLE, DIVIDE, FIXUP, DONE.
- IDLE:
  - On the edge where start=1, capture the operands and isSigned.
  - If divisor == 0, go to DONE.
  - Otherwise compute magnitudes:
    - Signed mode: absolute value of each operand. -2^(W-1) stays 0x80000000 as an unsigned magnitude.
    - Unsigned mode: raw operand.
  - Record negQ = isSigned & (dividend sign XOR divisor sign).
  - Record negR = isSigned & dividend sign.
  - Load remainder R = 0, quotient Q = |dividend|, counter = WIDTH-1, then go to DIVIDE.
- DIVIDE, one step per cycle, exactly WIDTH cycles:
  - Form T = {R, Q[W-1]} - {0, |divisor|}, using a WIDTH+1-bit subtract.
  - If T is non-negative: R = T[W-1:0] and Q = {Q[W-2:0], 1}.
  - Otherwise: R = {R[W-2:0], Q[W-1]} and Q = {Q[W-2:0], 0}.
  - When counter == 0, go to FIXUP; otherwise decrement the counter.
- FIXUP, one cycle:
  - ansLO = negQ ? -Q : Q.
  - ansHI = negR ? -R : R.
  - Go to DONE.
- DONE, one cycle:
  - done = 1 and busy = 0, then return to IDLE.
- busy is 1 in DIVIDE and FIXUP, and 0 in IDLE and DONE.
- Latency:
  - Start sampled at edge E0 → done high during the cycle after edge E0+WIDTH+2, i.e. 34 cycles for WIDTH=32.
  - Back-to-back: a start in the cycle immediately after done is accepted.
- Divide by zero:
  - Start at E0 → done and divByZero high after E1.
  - ansLO = all ones; ansHI = dividend unchanged.
  - divByZero clears when the next start is accepted.
- Signed overflow: -2^31 / -1 → ansLO = 0x80000000, ansHI = 0, divByZero = 0. No trap is raised.
- Rounding: the quotient truncates toward zero. A nonzero remainder has the sign of the dividend.
- Result holding:
  - ansHI and ansLO hold their values from FIXUP (or from DONE for divide-by-zero) until the next accepted start or reset.
  - Intermediate values are never driven onto ansHI/ansLO.
- start while busy or in DONE is ignored. Operand changes after capture have no effect.

Test Plan:
- Unsigned, isSigned=0, 100 / 7 → after 34 cycles: done pulse, ansLO=14, ansHI=2, divByZero=0; busy high for exactly 33 cycles.
- Signed negative dividend, isSigned=1:
  - -100 / 7 → ansLO=0xFFFFFFF2 (-14), ansHI=0xFFFFFFFE (-2).
  - 100 / -7 → ansLO=0xFFFFFFF2, ansHI=2.
- Unsigned large, isSigned=0, 0xFFFFFFFF / 2 → ansLO=0x7FFFFFFF, ansHI=1. Then, signed, 0x80000000 / 0xFFFFFFFF → ansLO=0x80000000, ansHI=0.
- Divide by zero: 0x12345678 / 0 → done and divByZero one cycle after the start edge; ansLO=0xFFFFFFFF, ansHI=0x12345678. The next valid start clears divByZero.
- Handshake robustness:
  - A start pulse at cycle 5 of an operation with different operands is ignored; the first result is unchanged.
  - A start issued the cycle after done is accepted.
- Reset mid-operation: assert reset at cycle 10 of 1000 / 3 → all outputs 0 immediately (asynchronously) and no done pulse. A fresh 9 / 3 then gives ansLO=3, ansHI=0.
